ex_addsub_stage: RTL
====================

Name: ex_addsub_stage

Overview:
- Execute-stage front end for the integer datapath. It sits between the ID/EX pipeline register and the EX/MEM register, directly upstream of the Han-Carlson adder.
- It decodes the add-class op and drives the adder operands and carry-in combinationally. The same cycle, it takes back sum and carry-out and forms ADD/SUB/SLT/SLTU results.
- Results are queued in a 2-entry output skid buffer with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32 (`WORD_WIDTH): datapath width; must match the adder.
- TAG_W, 5: destination-register tag width, passed through unchanged.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_flush  in  1  synchronous pipeline flush; discards buffered results.
- i_valid  in  1  upstream op valid.
- o_ready  out  1  stage can accept an op this cycle.
- i_op  in  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_tag  in  TAG_W  destination tag.
- o_adder_a  out  WIDTH  to adder i_A.
- o_adder_b  out  WIDTH  to adder i_B.
- o_adder_cin  out  1  to adder i_carryIn.
- i_adder_sum  in  WIDTH  from adder o_Out.
- i_adder_cout  in  1  from adder carry-out (MSB carry).
- o_valid  out  1  result at buffer head valid.
- i_ready  in  1  downstream accepts head.
- o_result  out  WIDTH  head result.
- o_tag  out  TAG_W  head tag.
- o_ovf  out  1  head signed-overflow flag.

Behaviour:
- Operand drive, purely combinational from inputs:
  - o_adder_a = i_a.
  - For ADD: o_adder_b = i_b and o_adder_cin = 0.
  - For SUB/SLT/SLTU: o_adder_b = ~i_b and o_adder_cin = 1.
  - Operand drive is independent of i_valid.
- Result formation, using S = i_adder_sum and Bx = o_adder_b:
  - V = (i_a[W-1] == Bx[W-1]) & (S[W-1] != i_a[W-1]).
  - ADD/SUB: result = S; ovf = V.
  - SLT: result = {0..0, S[W-1]^V}; ovf = 0.
  - SLTU: result = {0..0, ~i_adder_cout}; ovf = 0.
  - All arithmetic is modulo 2^WIDTH; there is no trap, ovf is a flag only.
- Handshakes:
  - push = i_valid & o_ready.
  - pop = o_valid & i_ready.
  - o_ready = (count < 2). It is a function of the registered count only and has no combinational path from i_ready.
- Buffer:
  - 2-entry FIFO {result, tag, ovf}; count 0..2.
  - Head output is registered: o_valid = (count != 0).
  - Latency: an op pushed in cycle N appears at o_valid in cycle N+1 when the buffer was empty or popped in cycle N.
  - Sustained throughput is 1 op/cycle while i_ready = 1.
- Count states:
  - EMPTY(0): push -> ONE.
  - ONE(1): push&~pop -> TWO; pop&~push -> EMPTY; push&pop -> ONE, new entry becomes head next cycle.
  - TWO(2): o_ready = 0, so no push; pop -> ONE, second entry moves to head.
- Ordering is strictly FIFO; head data is held stable while o_valid & ~i_ready.
- Flush: i_flush = 1 forces count to 0 next cycle. A same-cycle push is discarded, as is a same-cycle pop, which the downstream ignores under flush.
- Priority: reset > flush > push/pop.
- Reset (i_rst_n = 0 at a clock edge):
  - count = 0, o_valid = 0, o_result = 0, o_tag = 0, o_ovf = 0.
  - o_ready reads 1 from the first cycle after reset.
  - Reset mid-stream discards all buffered entries.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, tag 3, i_ready = 1 -> next cycle o_valid = 1, o_result = 0x80000000, o_ovf = 1, o_tag = 3; adder saw b = 0x00000001, cin = 0.
- SUB 0x00000005 - 0x00000007 -> o_adder_b = 0xFFFFFFF8, cin = 1; o_result = 0xFFFFFFFE, o_ovf = 0.
- SLT a = 0x80000000, b = 0x00000001 -> result 1. SLTU with the same operands -> result 0. SLTU a = 0, b = 1 -> result 1.
- Backpressure: i_ready = 0, push ops with tags 1, 2, 3 on consecutive cycles -> o_ready drops after two accepts, tag 3 is held upstream. Raise i_ready -> outputs tags 1, 2, 3 in order, o_ready re-asserts the cycle after the first pop.
- Simultaneous push and pop at count = 1 -> count stays 1, no bubble, 1 result/cycle for 8 back-to-back ops.
- Flush at count = 2 with a concurrent push -> next cycle o_valid = 0, o_ready = 1. Assert i_rst_n = 0 mid-stream -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ex_addsub_stage.sv
// ex_addsub_stage
//   Execute-stage front end for the add-class integer ops. It drives the external
//   adder operands and carry-in combinationally and forms ADD/SUB/SLT/SLTU results
//   from the returned sum and carry-out. Results are queued in a 2-entry output skid
//   buffer that has valid/ready handshakes on both sides.
//
// Ports
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_flush            synchronous flush; empties the buffer and drops a same-cycle push
//   i_valid / o_ready  upstream handshake; o_ready depends on registered state only
//   i_op, i_a, i_b     op (00 ADD, 01 SUB, 10 SLT, 11 SLTU) and operands
//   i_tag              destination tag, passed through unchanged
//   o_adder_a/b/cin    to the adder
//   i_adder_sum/cout   from the adder (same cycle)
//   o_valid / i_ready  downstream handshake on the buffer head
//   o_result, o_tag    head result and tag
//   o_ovf              head signed-overflow flag (ADD/SUB only)
module ex_addsub_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic [WIDTH-1:0] o_adder_a,
    output logic [WIDTH-1:0] o_adder_b,
    output logic             o_adder_cin,
    input  logic [WIDTH-1:0] i_adder_sum,
    input  logic             i_adder_cout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_ovf
);

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpSlt  = 2'b10;
    localparam logic [1:0] OpSltu = 2'b11;

    // State encodes the buffer occupancy directly.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    entry_t           new_entry;
    logic [WIDTH-1:0] b_x;
    logic             ovf_raw;
    logic             push;
    logic             pop;

    // Operand drive: subtraction-style ops use a + ~b + 1, independent of i_valid.
    always_comb begin
        o_adder_a = i_a;
        if (i_op == OpAdd) begin
            b_x         = i_b;
            o_adder_cin = 1'b0;
        end else begin
            b_x         = ~i_b;
            o_adder_cin = 1'b1;
        end
        o_adder_b = b_x;
    end

    // Signed overflow: operands to the adder agree in sign but the sum does not.
    assign ovf_raw = (i_a[WIDTH-1] == b_x[WIDTH-1]) & (i_adder_sum[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        new_entry.result = i_adder_sum;
        new_entry.tag    = i_tag;
        new_entry.ovf    = 1'b0;
        unique case (i_op)
            OpAdd, OpSub: new_entry.ovf = ovf_raw;
            // a < b signed: sign of a - b, corrected when the subtraction overflowed.
            OpSlt:  new_entry.result = {{(WIDTH-1){1'b0}}, i_adder_sum[WIDTH-1] ^ ovf_raw};
            // a < b unsigned: a - b borrowed, i.e. no carry out of a + ~b + 1.
            OpSltu: new_entry.result = {{(WIDTH-1){1'b0}}, ~i_adder_cout};
            default: ;
        endcase
    end

    assign o_ready = (state_q != StTwo);
    assign o_valid = (state_q != StEmpty);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (i_flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_d  = new_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        state_d = StTwo;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign o_result = head_q.result;
    assign o_tag    = head_q.tag;
    assign o_ovf    = head_q.ovf;

endmodule
